// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready stage register with 2-entry skid, flush and stall counter; PIPE_SKID_ZERO_BUBBLE_EN zeroes out_data on empty
module pipe_skid_reg #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter int             CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t           r_state;
  logic [W-1:0]     r_main;
  logic [W-1:0]     r_skid;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_in_fire;
  logic             w_out_fire;
  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_main;
  assign stall_cnt  = r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state     <= EMPTY;
      r_main      <= RST_VAL;
      r_skid      <= RST_VAL;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          r_main      <= in_data;
          r_state     <= BUSY;
          r_out_valid <= 1'b1;
        end
        BUSY: if (w_in_fire && w_out_fire) begin
          r_main <= in_data;
        end else if (w_in_fire) begin
          r_skid     <= in_data;
          r_state    <= FULL;
          r_in_ready <= 1'b0;
        end else if (w_out_fire) begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
`ifdef PIPE_SKID_ZERO_BUBBLE_EN
          r_main      <= RST_VAL;
`endif
        end
        FULL: if (w_out_fire) begin
          r_main     <= r_skid;
          r_state    <= BUSY;
          r_in_ready <= 1'b1;
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end
  // flush deliberately leaves the counter alone
  always_ff @(posedge clk) begin
    if (rst) r_stall_cnt <= '0;
    else if (r_out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks of handshake, skid, flush, saturation and bubble content
module tb_pipe_skid_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [3:0]  stall_cnt;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] bubble_exp;
  pipe_skid_reg #(.W(32), .RST_VAL(32'h0), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask
  initial begin
`ifdef PIPE_SKID_ZERO_BUBBLE_EN
    bubble_exp = 32'h0;
`else
    bubble_exp = 32'h77;
`endif
    rst = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 1'b1);
    tick();
    chk("rst1_ov", 32'(out_valid), 32'd0);
    tick();
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd1);
    chk("rst_od", out_data, 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_ov", 32'(out_valid), 32'd1);
    chk("first_od", out_data, 32'hDEADBEEF);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("first_drain_ov", 32'(out_valid), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      tick();
      chk("stream_ov", 32'(out_valid), 32'd1);
      chk("stream_od", out_data, 32'(i));
      chk("stream_ir", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream_end_ov", 32'(out_valid), 32'd0);
    chk("stream_cnt", 32'(stall_cnt), 32'd0);
    drive(1'b1, 32'hA, 1'b1);
    tick();
    chk("bp_a_od", out_data, 32'hA);
    drive(1'b1, 32'hB, 1'b0);
    tick();
    chk("bp_full_ir", 32'(in_ready), 32'd0);
    chk("bp_full_ov", 32'(out_valid), 32'd1);
    chk("bp_full_od", out_data, 32'hA);
    chk("bp_cnt1", 32'(stall_cnt), 32'd1);
    drive(1'b1, 32'hC, 1'b0);
    tick();
    chk("bp_hold_ir", 32'(in_ready), 32'd0);
    chk("bp_hold_od", out_data, 32'hA);
    chk("bp_cnt2", 32'(stall_cnt), 32'd2);
    drive(1'b1, 32'hC, 1'b1);
    tick();
    chk("bp_b_od", out_data, 32'hB);
    chk("bp_b_ir", 32'(in_ready), 32'd1);
    chk("bp_b_ov", 32'(out_valid), 32'd1);
    tick();
    chk("bp_c_od", out_data, 32'hC);
    chk("bp_c_ov", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("bp_end_ov", 32'(out_valid), 32'd0);
    chk("bp_end_cnt", 32'(stall_cnt), 32'd2);
    drive(1'b1, 32'h21, 1'b1);
    tick();
    drive(1'b1, 32'h22, 1'b0);
    tick();
    chk("fl_full_ir", 32'(in_ready), 32'd0);
    chk("fl_cnt3", 32'(stall_cnt), 32'd3);
    flush = 1'b1;
    drive(1'b1, 32'h55, 1'b0);
    tick();
    flush = 1'b0;
    chk("fl_ov", 32'(out_valid), 32'd0);
    chk("fl_ir", 32'(in_ready), 32'd1);
    chk("fl_od", out_data, 32'h0);
    chk("fl_cnt4", 32'(stall_cnt), 32'd4);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("fl_after_ov", 32'(out_valid), 32'd0);
    drive(1'b1, 32'h66, 1'b1);
    tick();
    chk("fl_next_od", out_data, 32'h66);
    drive(1'b1, 32'h77, 1'b1);
    tick();
    chk("bub_77_od", out_data, 32'h77);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("bub_ov", 32'(out_valid), 32'd0);
    chk("bub_od", out_data, bubble_exp);
    tick();
    chk("bub_od2", out_data, bubble_exp);
    drive(1'b1, 32'h99, 1'b0);
    tick();
    chk("sat_load_od", out_data, 32'h99);
    chk("sat_start_cnt", 32'(stall_cnt), 32'd4);
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("sat_cnt", 32'(stall_cnt), (i + 5 > 15) ? 32'd15 : 32'(i + 5));
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("sat_drain_ov", 32'(out_valid), 32'd0);
    chk("sat_hold_cnt", 32'(stall_cnt), 32'd15);
    drive(1'b1, 32'hAB, 1'b0);
    tick();
    chk("mid_load_od", out_data, 32'hAB);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_ir", 32'(in_ready), 32'd1);
    chk("mid_rst_od", out_data, 32'h0);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
